// File: rtl/avalon_ram_model_pkg.sv
// Shared types and helpers for the Avalon-MM RAM model: FSM states,
// address constants and the byte-lane write merge.
package avalon_ram_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;
  localparam int          WORD_BYTES        = 4;

  // Lanes with be[i]=1 take the new byte; the others keep the stored byte.
  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/avalon_ram_array.sv
// DEPTH x 32 storage with a byte-enabled bus write port, a preload port and
// a combinational read port. Contents are deliberately not reset.
module avalon_ram_array
  import avalon_ram_model_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_be,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [31:0]              rd_data
);

  logic [31:0] mem_r [DEPTH];
  logic        load_ok_s;

  // A bus write to the same word takes priority over the preload.
  assign load_ok_s = load_en && !(wr_en && (wr_idx == load_idx));
  assign rd_data   = mem_r[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= byte_merge(mem_r[wr_idx], wr_data, wr_be);
    end
    if (load_ok_s) begin
      mem_r[load_idx] <= load_data;
    end
  end

endmodule

// File: rtl/avalon_ram_model.sv
// Avalon-MM slave RAM model with programmable wait states, byte-lane writes,
// a preload port, sticky error flags and access counters.
module avalon_ram_model
  import avalon_ram_model_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = MIPS_RESET_VECTOR,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic                     waitrequest,
  output logic [31:0]              readdata,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     err_range,
  output logic                     err_align,
  output logic                     err_proto,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(WORD_BYTES * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t          state_r, next_state_s;
  logic [3:0]      cnt_r;
  logic [31:0]     addr_r;
  logic [31:0]     wdata_r;
  logic [3:0]      be_r;
  logic            op_wr_r;
  logic [AW-1:0]   idx_r;
  logic            in_range_r;
  logic [31:0]     readdata_r;
  logic            err_range_r, err_align_r, err_proto_r;
  logic [31:0]     rd_count_r, wr_count_r;

  logic            req_s, op_wr_s, abort_s;
  logic [31:0]     offset_s;
  logic            in_range_s;
  logic [AW-1:0]   idx_s;
  logic [31:0]     rd_data_s;
  logic            waitrequest_s, take_s, commit_s, enter_ack_s;

  // Simultaneous read and write is treated as a read.
  assign req_s   = read | write;
  assign op_wr_s = write & ~read;
  assign abort_s = !req_s || (address != addr_r) || (op_wr_s != op_wr_r);

  // Misaligned addresses are truncated to the containing word before decode.
  assign offset_s   = {address[31:2], 2'b00} - BASE_ADDR;
  assign in_range_s = (offset_s < SPAN);
  assign idx_s      = offset_s[AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          next_state_s = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (abort_s) begin
          next_state_s = IDLE;
        end else if (cnt_r == 4'd1) begin
          next_state_s = ACK;
        end else begin
          next_state_s = WAIT;
        end
      end
      ACK:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  always_comb begin
    waitrequest_s = 1'b0;
    take_s        = 1'b0;
    commit_s      = 1'b0;
    case (state_r)
      IDLE: begin
        waitrequest_s = req_s;
        take_s        = req_s;
      end
      WAIT:    waitrequest_s = req_s;
      ACK:     commit_s      = op_wr_r && in_range_r;
      default: waitrequest_s = 1'b0;
    endcase
    enter_ack_s = (next_state_s == ACK);
  end

  avalon_ram_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk      (clk),
    .wr_en    (commit_s),
    .wr_idx   (idx_r),
    .wr_data  (wdata_r),
    .wr_be    (be_r),
    .load_en  (load_en),
    .load_idx (load_addr),
    .load_data(load_data),
    .rd_idx   (idx_s),
    .rd_data  (rd_data_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r      <= 4'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      be_r       <= 4'd0;
      op_wr_r    <= 1'b0;
      idx_r      <= '0;
      in_range_r <= 1'b0;
    end else if (take_s) begin
      cnt_r      <= WAIT_INIT;
      addr_r     <= address;
      wdata_r    <= writedata;
      be_r       <= byteenable;
      op_wr_r    <= op_wr_s;
      idx_r      <= idx_s;
      in_range_r <= in_range_s;
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Read data is captured on entry to ACK so preloads during WAIT are seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_r  <= 32'd0;
      err_range_r <= 1'b0;
      err_align_r <= 1'b0;
      err_proto_r <= 1'b0;
      rd_count_r  <= 32'd0;
      wr_count_r  <= 32'd0;
    end else begin
      if (enter_ack_s && !op_wr_s) begin
        readdata_r <= in_range_s ? rd_data_s : 32'd0;
      end
      if (take_s && !in_range_s) begin
        err_range_r <= 1'b1;
      end
      if (take_s && (address[1:0] != 2'b00)) begin
        err_align_r <= 1'b1;
      end
      if ((take_s && read && write) || ((state_r == WAIT) && abort_s)) begin
        err_proto_r <= 1'b1;
      end
      if (state_r == ACK) begin
        if (op_wr_r) begin
          wr_count_r <= wr_count_r + 32'd1;
        end else begin
          rd_count_r <= rd_count_r + 32'd1;
        end
      end
    end
  end

  assign waitrequest = waitrequest_s;
  assign readdata    = readdata_r;
  assign err_range   = err_range_r;
  assign err_align   = err_align_r;
  assign err_proto   = err_proto_r;
  assign rd_count    = rd_count_r;
  assign wr_count    = wr_count_r;

endmodule

// File: tb/tb_avalon_ram_model.sv
// Bench for avalon_ram_model: four instances (WAIT_CYCLES 1,0,3,7) driven by
// per-instance bus tasks, with expected read data queued before each read.
module tb_avalon_ram_model;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_a    [N];
  logic        read_a       [N];
  logic        write_a      [N];
  logic [31:0] writedata_a  [N];
  logic [3:0]  byteenable_a [N];
  logic        load_en_a    [N];
  logic [7:0]  load_addr_a  [N];
  logic [31:0] load_data_a  [N];
  logic        waitrequest_a[N];
  logic [31:0] readdata_a   [N];
  logic        err_range_a  [N];
  logic        err_align_a  [N];
  logic        err_proto_a  [N];
  logic [31:0] rd_count_a   [N];
  logic [31:0] wr_count_a   [N];

  logic [31:0] exp_rd[N];
  logic [31:0] exp_wr[N];
  logic [31:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    avalon_ram_model #(
      .DEPTH      (256),
      .BASE_ADDR  (32'hBFC00000),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address_a[g]),
      .read       (read_a[g]),
      .write      (write_a[g]),
      .writedata  (writedata_a[g]),
      .byteenable (byteenable_a[g]),
      .waitrequest(waitrequest_a[g]),
      .readdata   (readdata_a[g]),
      .load_en    (load_en_a[g]),
      .load_addr  (load_addr_a[g]),
      .load_data  (load_data_a[g]),
      .err_range  (err_range_a[g]),
      .err_align  (err_align_a[g]),
      .err_proto  (err_proto_a[g]),
      .rd_count   (rd_count_a[g]),
      .wr_count   (wr_count_a[g])
    );
  end

  function automatic int wc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  // Called at posedge+1.
  task automatic preload(input int k, input int idx, input logic [31:0] data);
    load_en_a[k]   = 1'b1;
    load_addr_a[k] = 8'(idx);
    load_data_a[k] = data;
    @(posedge clk); #1;
    load_en_a[k] = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the ACK edge.
  task automatic bus_access(input int k, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be,
                            output logic [31:0] rdata, output int stall);
    bit done;
    done  = 1'b0;
    stall = 0;
    rdata = 32'h0;
    address_a[k]    = addr;
    read_a[k]       = !wr;
    write_a[k]      = wr;
    writedata_a[k]  = data;
    byteenable_a[k] = be;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (waitrequest_a[k]) begin
        stall++;
      end else begin
        rdata = readdata_a[k];
        done  = 1'b1;
      end
      @(posedge clk); #1;
    end
    read_a[k]  = 1'b0;
    write_a[k] = 1'b0;
    if (done) begin
      if (wr) exp_wr[k] = exp_wr[k] + 32'd1;
      else    exp_rd[k] = exp_rd[k] + 32'd1;
    end else begin
      tests++; fails++;
      $display("FAIL handshake_timeout inst=%0d addr=%h: no completion in 40 cycles", k, addr);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      tests++;
      if (waitrequest_a[k] !== 1'b0) begin fails++; $display("FAIL reset_waitrequest inst=%0d got %b want 0", k, waitrequest_a[k]); end
      tests++;
      if (readdata_a[k] !== 32'h0) begin fails++; $display("FAIL reset_readdata inst=%0d got %h want 0", k, readdata_a[k]); end
      tests++;
      if ({err_range_a[k], err_align_a[k], err_proto_a[k]} !== 3'b000) begin
        fails++; $display("FAIL reset_flags inst=%0d got %b want 000", k, {err_range_a[k], err_align_a[k], err_proto_a[k]});
      end
      tests++;
      if (rd_count_a[k] !== 32'h0 || wr_count_a[k] !== 32'h0) begin
        fails++; $display("FAIL reset_counts inst=%0d got rd=%0d wr=%0d want 0/0", k, rd_count_a[k], wr_count_a[k]);
      end
    end
  endtask

  task automatic test_preload_read();
    logic [31:0] rd, exp;
    int st;
    preload(0, 1, 32'h2402A234);
    preload(0, 2, 32'h00021202);
    exp_q.push_back(32'h2402A234);
    bus_access(0, 1'b0, 32'hBFC00004, 32'h0, 4'h0, rd, st);
    exp = exp_q.pop_front();
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL preload_read got %h want %h", rd, exp); end
    tests++;
    if (st !== 2) begin fails++; $display("FAIL preload_stall got %0d want 2", st); end
    tests++;
    if (rd_count_a[0] !== 32'd1) begin fails++; $display("FAIL preload_rd_count got %0d want 1", rd_count_a[0]); end
    exp_q.push_back(32'h00021202);
    bus_access(0, 1'b0, 32'hBFC00008, 32'h0, 4'h0, rd, st);
    exp = exp_q.pop_front();
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL preload_read2 got %h want %h", rd, exp); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, exp;
    int st;
    preload(0, 4, 32'h0);
    bus_access(0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'b0101, rd, st);
    tests++;
    if (wr_count_a[0] !== 32'd1) begin fails++; $display("FAIL be_wr_count got %0d want 1", wr_count_a[0]); end
    tests++;
    if (st !== 2) begin fails++; $display("FAIL be_write_stall got %0d want 2", st); end
    exp_q.push_back(32'h00AD00EF);
    bus_access(0, 1'b0, 32'hBFC00010, 32'h0, 4'h0, rd, st);
    exp = exp_q.pop_front();
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL be_readback got %h want %h", rd, exp); end
  endtask

  task automatic test_wait_sweep();
    logic [31:0] rd, exp;
    int st;
    for (int k = 1; k < N; k++) begin
      for (int w = 0; w < 3; w++) preload(k, 8 + w, 32'hA5000000 + 32'(k * 16 + w));
      for (int w = 0; w < 3; w++) exp_q.push_back(32'hA5000000 + 32'(k * 16 + w));
      for (int w = 0; w < 3; w++) begin
        bus_access(k, 1'b0, 32'hBFC00020 + 32'(4 * w), 32'h0, 4'h0, rd, st);
        exp = exp_q.pop_front();
        tests++;
        if (rd !== exp) begin fails++; $display("FAIL sweep_data inst=%0d word=%0d got %h want %h", k, w, rd, exp); end
        tests++;
        if (st !== wc_of(k) + 1) begin fails++; $display("FAIL sweep_stall inst=%0d got %0d want %0d", k, st, wc_of(k) + 1); end
      end
      tests++;
      if (rd_count_a[k] !== exp_rd[k]) begin fails++; $display("FAIL sweep_rd_count inst=%0d got %0d want %0d", k, rd_count_a[k], exp_rd[k]); end
      @(negedge clk);
      tests++;
      if (waitrequest_a[k] !== 1'b0) begin fails++; $display("FAIL sweep_idle_waitrequest inst=%0d got %b want 0", k, waitrequest_a[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, exp;
    int st;
    tests++;
    if (err_range_a[0] !== 1'b0) begin fails++; $display("FAIL range_before got %b want 0", err_range_a[0]); end
    exp_q.push_back(32'h0);
    bus_access(0, 1'b0, 32'hBFC00400, 32'h0, 4'h0, rd, st);
    exp = exp_q.pop_front();
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL range_readdata got %h want %h", rd, exp); end
    tests++;
    if (err_range_a[0] !== 1'b1) begin fails++; $display("FAIL range_flag got %b want 1", err_range_a[0]); end
    tests++;
    if (rd_count_a[0] !== exp_rd[0]) begin fails++; $display("FAIL range_rd_count got %0d want %0d", rd_count_a[0], exp_rd[0]); end
    tests++;
    if (err_align_a[0] !== 1'b0) begin fails++; $display("FAIL align_before got %b want 0", err_align_a[0]); end
    exp_q.push_back(32'h2402A234);
    bus_access(0, 1'b0, 32'hBFC00006, 32'h0, 4'h0, rd, st);
    exp = exp_q.pop_front();
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL align_readdata got %h want %h", rd, exp); end
    tests++;
    if (err_align_a[0] !== 1'b1) begin fails++; $display("FAIL align_flag got %b want 1", err_align_a[0]); end
    tests++;
    if (err_proto_a[0] !== 1'b0) begin fails++; $display("FAIL proto_before got %b want 0", err_proto_a[0]); end
    address_a[0] = 32'hBFC00008;
    read_a[0]    = 1'b1;
    @(posedge clk); #1;
    read_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (err_proto_a[0] !== 1'b1) begin fails++; $display("FAIL proto_flag got %b want 1", err_proto_a[0]); end
    tests++;
    if (rd_count_a[0] !== exp_rd[0]) begin fails++; $display("FAIL proto_rd_count got %0d want %0d", rd_count_a[0], exp_rd[0]); end
  endtask

  task automatic test_collision();
    logic [31:0] rd, exp;
    int st;
    bit done;
    done = 1'b0;
    address_a[0]    = 32'hBFC00014;
    write_a[0]      = 1'b1;
    writedata_a[0]  = 32'h22222222;
    byteenable_a[0] = 4'hF;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest_a[0]) begin
        load_en_a[0]   = 1'b1;
        load_addr_a[0] = 8'd5;
        load_data_a[0] = 32'h11111111;
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    write_a[0]   = 1'b0;
    load_en_a[0] = 1'b0;
    if (done) begin
      exp_wr[0] = exp_wr[0] + 32'd1;
    end else begin
      tests++; fails++;
      $display("FAIL collision_timeout: write never completed");
    end
    exp_q.push_back(32'h22222222);
    bus_access(0, 1'b0, 32'hBFC00014, 32'h0, 4'h0, rd, st);
    exp = exp_q.pop_front();
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL collision_readback got %h want %h", rd, exp); end
    tests++;
    if (wr_count_a[0] !== exp_wr[0]) begin fails++; $display("FAIL collision_wr_count got %0d want %0d", wr_count_a[0], exp_wr[0]); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, exp;
    int st;
    preload(0, 6, 32'h0);
    address_a[0]    = 32'hBFC00018;
    write_a[0]      = 1'b1;
    writedata_a[0]  = 32'h000000A2;
    byteenable_a[0] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_rd[k] = 32'd0;
      exp_wr[k] = 32'd0;
    end
    #2;
    tests++;
    if (rd_count_a[0] !== 32'd0 || wr_count_a[0] !== 32'd0) begin
      fails++; $display("FAIL midreset_counts got rd=%0d wr=%0d want 0/0", rd_count_a[0], wr_count_a[0]);
    end
    tests++;
    if ({err_range_a[0], err_align_a[0], err_proto_a[0]} !== 3'b000) begin
      fails++; $display("FAIL midreset_flags got %b want 000", {err_range_a[0], err_align_a[0], err_proto_a[0]});
    end
    tests++;
    if (readdata_a[0] !== 32'h0) begin fails++; $display("FAIL midreset_readdata got %h want 0", readdata_a[0]); end
    tests++;
    if (waitrequest_a[0] !== 1'b1) begin fails++; $display("FAIL midreset_waitrequest got %b want 1", waitrequest_a[0]); end
    @(negedge clk);
    write_a[0] = 1'b0;
    reset      = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'h0);
    bus_access(0, 1'b0, 32'hBFC00018, 32'h0, 4'h0, rd, st);
    exp = exp_q.pop_front();
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL midreset_word got %h want %h", rd, exp); end
    tests++;
    if (rd_count_a[0] !== exp_rd[0]) begin fails++; $display("FAIL midreset_rd_count got %0d want %0d", rd_count_a[0], exp_rd[0]); end
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      address_a[k]    = 32'h0;
      read_a[k]       = 1'b0;
      write_a[k]      = 1'b0;
      writedata_a[k]  = 32'h0;
      byteenable_a[k] = 4'h0;
      load_en_a[k]    = 1'b0;
      load_addr_a[k]  = 8'h0;
      load_data_a[k]  = 32'h0;
      exp_rd[k]       = 32'd0;
      exp_wr[k]       = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    test_preload_read();
    test_byte_enable();
    test_wait_sweep();
    test_errors();
    test_collision();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
